// File: rtl/ber_monitor.sv
// PRBS-7 (x^7 + x^6 + 1) bit-error-rate monitor: self-synchronises to the decoded
// test stream, then counts checked bits and errors with loss-of-lock supervision.
module ber_monitor #(
  parameter int CNT_W       = 32,
  parameter int SYNC_LEN    = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_pulse,
  output logic             sat
);

  localparam int MW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WINDOW + 1);

  localparam logic [MW-1:0] SYNC_M = MW'(SYNC_LEN);
  localparam logic [WW-1:0] WIN_M  = WW'(WINDOW);
  localparam logic [WW-1:0] THR_M  = WW'(LOSS_THRESH);

  typedef enum logic {
    S_HUNT,
    S_LOCKED
  } state_t;

  state_t        state;
  logic [6:0]    sr;
  logic [2:0]    fill;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_bits;
  logic [WW-1:0] win_errs;

  logic          pred;
  logic          mismatch;
  logic [MW-1:0] match_next;
  logic [WW-1:0] win_bits_next;
  logic [WW-1:0] win_errs_next;

  assign pred          = sr[6] ^ sr[5];
  assign mismatch      = bit_in ^ pred;
  assign match_next    = match_cnt + 1'b1;
  assign win_bits_next = win_bits + 1'b1;
  assign win_errs_next = win_errs + WW'(mismatch);
  assign locked        = (state == S_LOCKED);

  // NOTE: every register here is assigned with <= so all branches see the
  // pre-edge values of state, sr and the counters, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_HUNT;
      sr        <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      bit_count <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      sat       <= 1'b0;
    end else if (enb) begin
      err_pulse <= 1'b0;

      if (bit_valid) begin
        case (state)
          S_HUNT: begin
            sr <= {sr[5:0], bit_in};
            if (fill != 3'd7) begin
              fill <= fill + 3'd1;
            end else if (!mismatch && sr != '0) begin
              match_cnt <= match_next;
              if (match_next == SYNC_M) begin
                state    <= S_LOCKED;
                win_bits <= '0;
                win_errs <= '0;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          S_LOCKED: begin
            // Local generator free-runs so decoder errors cannot corrupt the reference.
            sr <= {sr[5:0], pred};
            if (win_bits_next == WIN_M) begin
              if (win_errs_next >= THR_M) begin
                state     <= S_HUNT;
                fill      <= '0;
                match_cnt <= '0;
              end
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits_next;
              win_errs <= win_errs_next;
            end
          end

          default: state <= S_HUNT;
        endcase
      end

      // Clear outranks a coincident sample: that bit is neither counted nor flagged.
      if (clear) begin
        bit_count <= '0;
        err_count <= '0;
        sat       <= 1'b0;
      end else if (bit_valid && state == S_LOCKED) begin
        if (bit_count == '1) sat <= 1'b1;
        else                 bit_count <= bit_count + 1'b1;
        if (mismatch) begin
          err_pulse <= 1'b1;
          if (err_count == '1) sat <= 1'b1;
          else                 err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ber_monitor.md
# ber_monitor

Receive-side bit-error-rate monitor for the audio link test path. It sits after the Viterbi decoder and consumes one decoded bit per qualified cycle. The transmit side injects a PRBS-7 pattern (x^7 + x^6 + 1) into the convolutional encoder in place of audio; this block self-synchronises to that pattern, then counts checked bits and bit errors. It gives an in-hardware BER figure, so decoder quality is measured without a bench-side delayed reference.

## Interface
Parameters:
- CNT_W, default 32: width of `bit_count` and `err_count`.
- SYNC_LEN, default 16: consecutive matches in HUNT required to declare lock.
- WINDOW, default 64: checked bits per loss-of-lock evaluation window.
- LOSS_THRESH, default 8: errors within one window that force a return to HUNT.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: reset is synchronous and active-low. Low at a rising edge resets all state.
- `enb`, in, 1: clock enable. When low, all state holds and `bit_valid` is ignored.
- `bit_in`, in, 1: decoded bit from the Viterbi decoder.
- `bit_valid`, in, 1: `bit_in` is qualified this cycle.
- `clear`, in, 1: synchronous clear of counters and `sat`. Lock state is unaffected.
- `locked`, out, 1: the monitor is in the LOCKED state.
- `bit_count`, out, CNT_W: bits checked while LOCKED.
- `err_count`, out, CNT_W: mismatches seen while LOCKED.
- `err_pulse`, out, 1: one-cycle strobe for each counted error.
- `sat`, out, 1: sticky flag, set when either counter saturates.

## Operation
- A sample is a rising edge with `enb`=1 and `bit_valid`=1. Nothing changes on any other edge except reset.
- State:
  - 7-bit shift register `sr`.
  - Fill counter, 0..7.
  - Match counter, 0..SYNC_LEN.
  - Window bit counter and window error counter.
  - Two-state FSM: HUNT and LOCKED.
- Prediction: `pred = sr[6] ^ sr[5]`.
- HUNT:
  - Every sample shifts `bit_in` into `sr[0]`.
  - While fill < 7: increment fill, no compare.
  - Once fill = 7: if `bit_in == pred` and `sr != 0`, increment the match counter. Otherwise clear the match counter to 0.
  - When the match counter reaches SYNC_LEN, go to LOCKED on that edge. The window counters are zeroed.
  - An all-zero `sr` never counts as a match, so an all-zero stream never locks.
- LOCKED:
  - `sr` free-runs: `pred` is shifted in, not `bit_in`.
  - Each sample increments `bit_count` and the window bit counter.
  - If `bit_in != pred`: increment `err_count` and the window error counter, and assert `err_pulse` for one cycle.
  - On the sample that brings the window bit count to WINDOW, evaluate the window error count, including the current bit.
  - If that count is ≥ LOSS_THRESH: go to HUNT and clear the fill and match counters. `sr` keeps its value.
  - Whether or not lock is lost, the window counters restart at 0.
- Counters:
  - Both counters are unsigned and saturate at 2^CNT_W−1; they never wrap.
  - A sample that would exceed all-ones holds the value and sets `sat`.
  - `err_pulse` still fires on a saturated error.
- Clear:
  - `clear`=1 with `enb`=1 zeroes `bit_count`, `err_count` and `sat`.
  - If a sample occurs on the same edge, clear wins: that bit is not counted and `err_pulse` stays low.
  - FSM, `sr` and window counters still advance normally.
- Reset:
  - All outputs go to 0 and the FSM enters HUNT.
  - `sr`, the fill, match and window counters all go to 0.
  - Applies mid-lock with no residual state.

## Timing
- All outputs are registered and change only on rising edges of `clk`.
- Sample-to-output latency is 1 cycle: values are visible after the edge that samples the bit.
- `locked` rises on the edge of the SYNC_LEN-th consecutive match and falls on the edge of the failing window's last bit.
- The bit that completes lock is not counted. Counting starts with the next sample.
- `err_pulse` is high for exactly the cycle after an error edge. Back-to-back errors give a continuous high.
- No backpressure: one bit is accepted per qualified cycle, and `bit_valid` may be held high indefinitely.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs. Required: `locked`=0, both counts 0, `err_pulse`=0, `sat`=0.
- Clean lock: PRBS-7 stream seeded 7'h7F, 100 valid bits. Required: `locked` rises after the 23rd bit; `bit_count`=77 and `err_count`=0 after the 100th.
- Single error: invert one bit while locked. Required: `err_count`=1, `err_pulse` high for one cycle, `locked` stays 1.
- Loss of lock: invert 8 bits within one 64-bit window. Required: `locked` falls on the window's last-bit edge; with clean bits thereafter, it relocks 23 bits later and `err_count` is preserved.
- All-zero input, 500 valid bits. Required: `locked` stays 0 and both counts stay 0. With `enb`=0, a `bit_valid` burst changes nothing.
- Saturation and clear: CNT_W=4, locked clean stream. Required: `bit_count` holds at 15 with `sat`=1. Pulse `clear` coincident with a valid bit: `bit_count`=0 and `sat`=0 next cycle, and that bit is not counted.
